// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_pkg : shared widths, master FSM states and master id codes   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        AR   = 3'd4,
        R    = 3'd5
    } state_t;

    localparam logic [3:0] W_ID0 = 4'b0001;
    localparam logic [3:0] W_ID1 = 4'b0010;
    localparam logic [3:0] W_ID2 = 4'b0100;
    localparam logic [3:0] W_ID3 = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/axi_wdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_wdog : clearable saturating idle counter with expiry flag    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over enable; the count parks at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_burst_master : single-outstanding AXI burst read/write master|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_burst_master #(
    parameter int ADDR_W  = axi_pkg::ADDR_W,
    parameter int DATA_W  = axi_pkg::DATA_W,
    parameter int ID_W    = axi_pkg::ID_W,
    parameter int LEN_W   = axi_pkg::LEN_W,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output logic              done_err,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic              bvalid,
    output logic              bready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);
    import axi_pkg::*;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic               r_b_seen;
    logic               r_err;
    logic               r_live;
    logic               r_done_valid;
    logic               r_done_err;

    logic               w_accept;
    logic               w_w_hs;
    logic               w_r_hs;
    logic               w_last_beat;
    logic               w_r_beat_err;
    logic               w_done;
    logic               w_done_err;
    logic               w_wdog_clr;
    logic               w_wdog_en;
    logic               w_tmo;
    logic               w_unused;

    assign w_unused     = ^{bid, 1'b0};
    assign w_last_beat  = (r_beat == r_len);
    assign w_w_hs       = (r_state == W) && wr_data_valid && wready;
    assign w_r_hs       = (r_state == R) && rvalid && rd_ready;
    assign w_r_beat_err = (rlast != w_last_beat) || (rid != r_id);
    // r_live keeps cmd_ready low while reset is held; no command in the done cycle.
    assign cmd_ready    = (r_state == IDLE) && r_live && !r_done_valid;
    assign w_accept     = cmd_ready && cmd_valid;

    axi_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .i_clr     (w_wdog_clr),
        .i_en      (w_wdog_en),
        .o_expired (w_tmo)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The write timer also counts the final W handshake cycle, so B expires TIMEOUT cycles after entry.
    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_done_err = 1'b0;
        w_wdog_clr = 1'b0;
        w_wdog_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_wdog_clr = 1'b1;
                if (w_accept) begin
                    w_next = cmd_write ? AW : AR;
                end
            end
            AW: begin
                w_wdog_clr = 1'b1;
                if (awready) begin
                    w_next = W;
                end
            end
            W: begin
                if (w_w_hs && w_last_beat) begin
                    w_next    = B;
                    w_wdog_en = 1'b1;
                end else begin
                    w_wdog_clr = 1'b1;
                end
            end
            B: begin
                if (r_b_seen || bvalid) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end else if (w_tmo) begin
                    w_next     = IDLE;
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else begin
                    w_wdog_en = 1'b1;
                end
            end
            AR: begin
                w_wdog_clr = 1'b1;
                if (arready) begin
                    w_next = R;
                end
            end
            R: begin
                if (w_r_hs) begin
                    w_wdog_clr = 1'b1;
                    if (w_last_beat) begin
                        w_next     = IDLE;
                        w_done     = 1'b1;
                        w_done_err = r_err || w_r_beat_err;
                    end
                end else if (w_tmo) begin
                    w_next     = IDLE;
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else begin
                    w_wdog_en = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_b_seen     <= 1'b0;
            r_err        <= 1'b0;
            r_live       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_done_valid <= w_done;
            r_done_err   <= w_done_err;
            if (w_accept) begin
                r_id     <= cmd_id;
                r_addr   <= cmd_addr;
                r_len    <= cmd_len;
                r_beat   <= '0;
                r_b_seen <= 1'b0;
                r_err    <= 1'b0;
            end
            // Beat holds at len on the final handshake so it never passes len.
            if ((w_w_hs || w_r_hs) && !w_last_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_w_hs && w_last_beat && bvalid) begin
                r_b_seen <= 1'b1;
            end
            if (w_r_hs && w_r_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign awvalid       = (r_state == AW);
    assign awid          = r_id;
    assign awaddr        = r_addr;
    assign awlen         = r_len;

    assign wvalid        = (r_state == W) && wr_data_valid;
    assign wdata         = (r_state == W) ? wr_data : '0;
    assign wid           = r_id;
    assign wlast         = (r_state == W) && w_last_beat;
    assign wr_data_ready = (r_state == W) && wready;
    assign bready        = (r_state == W) || (r_state == B);

    assign arvalid       = (r_state == AR);
    assign arid          = r_id;
    assign araddr        = r_addr;
    assign arlen         = r_len;

    assign rready        = (r_state == R) && rd_ready;
    assign rd_valid      = (r_state == R) && rvalid;
    assign rd_data       = (r_state == R) ? rdata : '0;
    assign rd_last       = (r_state == R) && w_last_beat;

    assign done_valid    = r_done_valid;
    assign done_id       = r_id;
    assign done_err      = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_burst_master : directed bench for axi_burst_master        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_axi_burst_master;
    import axi_pkg::*;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid, wr_data_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_last, rd_ready;
    logic              done_valid, done_err;
    logic [ID_W-1:0]   done_id;
    logic [ID_W-1:0]   awid, wid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [LEN_W-1:0]  awlen, arlen;
    logic              awvalid, awready, wlast, wvalid, wready;
    logic [DATA_W-1:0] wdata, rdata;
    logic              bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    int                checks = 0;
    int                errors = 0;
    int                b;
    logic [5:0]        rdy_pat;

    always #5 sys_clk = ~sys_clk;

    axi_burst_master #(
        .TIMEOUT (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_id        (cmd_id),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .rd_ready      (rd_ready),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .done_err      (done_err),
        .awid          (awid),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awvalid       (awvalid),
        .awready       (awready),
        .wid           (wid),
        .wdata         (wdata),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bid           (bid),
        .bvalid        (bvalid),
        .bready        (bready),
        .arid          (arid),
        .araddr        (araddr),
        .arlen         (arlen),
        .arvalid       (arvalid),
        .arready       (arready),
        .rid           (rid),
        .rdata         (rdata),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .rready        (rready)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [ID_W-1:0] id,
                         input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
    endtask

    initial begin
        sys_rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_data_valid = 1'b0; rd_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bvalid = 1'b0; arready = 1'b0;
        rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_rd_last", rd_last, 0);
        sys_rst = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        // Write id=1 addr=0x10 len=3, wready toggling
        issue(1'b1, W_ID0, 32'h10, 8'd3);
        tick();
        cmd_valid = 1'b0;
        #1;
        check("t1_awvalid", awvalid, 1);
        check("t1_awaddr", awaddr, 32'h10);
        check("t1_awlen", awlen, 3);
        check("t1_awid", awid, W_ID0);
        tick();
        check("t1_aw_hold", awaddr, 32'h10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        wr_data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wready  = i[0];
            wr_data = 32'hA0 + i / 2;
            #1;
            check("t1_wlast", wlast, (i / 2 == 3));
            check("t1_wdata", wdata, 32'hA0 + i / 2);
            check("t1_wr_data_ready", wr_data_ready, i[0]);
            tick();
        end
        wr_data_valid = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bid = W_ID0;
        #1;
        check("t1_bready", bready, 1);
        check("t1_no_early_done", done_valid, 0);
        tick();
        bvalid = 1'b0;
        check("t1_done_valid", done_valid, 1);
        check("t1_done_id", done_id, W_ID0);
        check("t1_done_err", done_err, 0);
        check("t1_no_cmd_on_done", cmd_ready, 0);
        tick();
        check("t1_done_pulse", done_valid, 0);
        check("t1_cmd_ready", cmd_ready, 1);

        // Read id=2 addr=0x10 len=3, rd_ready low two cycles mid-burst
        issue(1'b0, W_ID1, 32'h10, 8'd3);
        tick();
        cmd_valid = 1'b0; arready = 1'b1;
        #1;
        check("t2_arvalid", arvalid, 1);
        check("t2_araddr", araddr, 32'h10);
        check("t2_arlen", arlen, 3);
        check("t2_arid", arid, W_ID1);
        tick();
        arready = 1'b0;
        rdy_pat = 6'b110011;
        b = 0;
        for (int j = 0; j < 6; j++) begin
            rd_ready = rdy_pat[j];
            rvalid = 1'b1; rid = W_ID1;
            rdata = 32'hA0 + b; rlast = (b == 3);
            #1;
            check("t2_rd_valid", rd_valid, 1);
            check("t2_rd_data", rd_data, 32'hA0 + b);
            check("t2_rd_last", rd_last, (b == 3));
            check("t2_rready", rready, rdy_pat[j]);
            tick();
            if (rdy_pat[j]) b++;
        end
        rvalid = 1'b0; rd_ready = 1'b0;
        check("t2_done_valid", done_valid, 1);
        check("t2_done_id", done_id, W_ID1);
        check("t2_done_err", done_err, 0);
        tick();

        // Write len=0, bvalid in the same cycle as the wlast handshake
        issue(1'b1, W_ID2, 32'h20, 8'd0);
        tick();
        cmd_valid = 1'b0; awready = 1'b1;
        #1;
        check("t3_awlen", awlen, 0);
        check("t3_awaddr", awaddr, 32'h20);
        tick();
        awready = 1'b0;
        wr_data_valid = 1'b1; wready = 1'b1; wr_data = 32'h55;
        bvalid = 1'b1; bid = W_ID2;
        #1;
        check("t3_wlast", wlast, 1);
        check("t3_wdata", wdata, 32'h55);
        check("t3_bready_w", bready, 1);
        tick();
        wr_data_valid = 1'b0; wready = 1'b0; bvalid = 1'b0;
        #1;
        check("t3_in_b", done_valid, 0);
        tick();
        check("t3_done_valid", done_valid, 1);
        check("t3_done_id", done_id, W_ID2);
        check("t3_done_err", done_err, 0);
        tick();

        // Write where B never comes: err exactly 16 cycles after entering B
        issue(1'b1, W_ID3, 32'h30, 8'd1);
        tick();
        cmd_valid = 1'b0; awready = 1'b1;
        tick();
        awready = 1'b0;
        wr_data_valid = 1'b1; wready = 1'b1; wr_data = 32'hB0;
        #1;
        check("t4_wlast0", wlast, 0);
        tick();
        wr_data = 32'hB1;
        #1;
        check("t4_wlast1", wlast, 1);
        tick();
        wr_data_valid = 1'b0; wready = 1'b0;
        check("t4_enter_b", done_valid, 0);
        for (int n = 1; n < 16; n++) begin
            tick();
        end
        check("t4_not_early", done_valid, 0);
        tick();
        check("t4_done_valid", done_valid, 1);
        check("t4_done_err", done_err, 1);
        check("t4_done_id", done_id, W_ID3);
        tick();

        // Read len=3 with rlast on beat 2
        issue(1'b0, W_ID0, 32'h10, 8'd3);
        tick();
        cmd_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rvalid = 1'b1; rd_ready = 1'b1; rid = W_ID0;
            rdata = 32'hC0 + j; rlast = (j == 2);
            #1;
            check("t5_rd_last", rd_last, (j == 3));
            check("t5_rd_data", rd_data, 32'hC0 + j);
            tick();
            if (j == 2) check("t5_not_early", done_valid, 0);
        end
        rvalid = 1'b0; rd_ready = 1'b0; rlast = 1'b0;
        check("t5_done_valid", done_valid, 1);
        check("t5_done_err", done_err, 1);
        tick();

        // Reset during W at beat 2
        issue(1'b1, W_ID0, 32'h40, 8'd3);
        tick();
        cmd_valid = 1'b0; awready = 1'b1;
        tick();
        awready = 1'b0;
        wr_data_valid = 1'b1; wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data = 32'hD0 + i;
            tick();
        end
        wr_data = 32'hD2;
        sys_rst = 1'b1;
        #1;
        check("t6_wvalid", wvalid, 0);
        check("t6_wr_data_ready", wr_data_ready, 0);
        check("t6_wdata", wdata, 0);
        check("t6_wlast", wlast, 0);
        check("t6_bready", bready, 0);
        check("t6_awaddr", awaddr, 0);
        check("t6_cmd_ready", cmd_ready, 0);
        check("t6_done_valid", done_valid, 0);
        tick();
        check("t6_no_done", done_valid, 0);
        sys_rst = 1'b0; wr_data_valid = 1'b0; wready = 1'b0;
        tick();
        check("t6_post_no_done", done_valid, 0);
        check("t6_post_cmd_ready", cmd_ready, 1);
        issue(1'b1, W_ID1, 32'h50, 8'd1);
        tick();
        cmd_valid = 1'b0; awready = 1'b1;
        #1;
        check("t6_awaddr_new", awaddr, 32'h50);
        check("t6_awid_new", awid, W_ID1);
        tick();
        awready = 1'b0;
        wr_data_valid = 1'b1; wready = 1'b1; wr_data = 32'hE0;
        #1;
        check("t6_beat0_wlast", wlast, 0);
        tick();
        wr_data = 32'hE1;
        #1;
        check("t6_beat1_wlast", wlast, 1);
        bvalid = 1'b1; bid = W_ID1;
        tick();
        wr_data_valid = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();
        check("t6_done_valid", done_valid, 1);
        check("t6_done_id", done_id, W_ID1);
        check("t6_done_err", done_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Single-outstanding AXI burst master that drives the team's AXI slave/RAM block through the interconnect.
- Converts simple user commands (read or write, id, address, length) into AW/W/B or AR/R channel sequences.
- Streams write data in and read data out.
- Reports per-command completion, including an error flag for response timeout or RLAST mismatch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, transaction id width
- LEN_W, 8, burst length field width (beats = len+1)
- TIMEOUT, 255, max idle cycles waiting for B response or next R beat

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_id  in  ID_W  transaction id
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wr_data  in  DATA_W  write stream data
- wr_data_valid  in  1  write stream valid
- wr_data_ready  out  1  write stream ready
- rd_data  out  DATA_W  read stream data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final beat (count-based)
- rd_ready  in  1  read stream ready
- done_valid  out  1  one-cycle completion pulse
- done_id  out  ID_W  completed id
- done_err  out  1  timeout or RLAST mismatch
- awid/awaddr/awlen/awvalid  out  ID_W/ADDR_W/LEN_W/1  AXI AW
- awready  in  1
- wid/wdata/wlast/wvalid  out  ID_W/DATA_W/1/1  AXI W
- wready  in  1
- bid/bvalid  in  ID_W/1  AXI B
- bready  out  1
- arid/araddr/arlen/arvalid  out  ID_W/ADDR_W/LEN_W/1  AXI AR
- arready  in  1
- rid/rdata/rlast/rvalid  in  ID_W/DATA_W/1/1  AXI R
- rready  out  1

Behaviour:
- Reset and clock: reset is asynchronous and active-high on sys_rst; single clock sys_clk. On reset, state=IDLE, all counters and latched fields=0, every output=0.
- Reset mid-burst: reset abandons the burst with no done pulse.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch id/addr/len/write.
  - Go to AW if write, else AR.
  - Clear beat counter and timer.
- AW:
  - awvalid=1; awid/awaddr/awlen come from latched registers and are held stable while awvalid.
  - awvalid&&awready -> W.
- W:
  - wvalid=wr_data_valid, wdata=wr_data, wr_data_ready=wready; all combinational pass-through.
  - wid=latched id; wlast=(beat==len).
  - Each wvalid&&wready handshake increments beat.
  - Handshake with wlast -> B.
  - beat wraps never exceed len.
- B:
  - bready=1 in both W and B, because the slave pulses bvalid for a single cycle.
  - A bvalid seen in W on or after the last handshake sets b_seen.
  - In B: b_seen or bvalid -> done, back to IDLE.
  - Otherwise the timer increments each cycle; timer==TIMEOUT -> done with done_err=1.
- AR:
  - arvalid=1 with latched fields; arvalid&&arready -> R.
- R:
  - rready=rd_ready; rd_valid=rvalid; rd_data=rdata; rd_last=(beat==len).
  - Each rvalid&&rready handshake increments beat and clears the timer.
  - A handshake at beat==len -> done, IDLE.
  - rlast asserted at beat!=len, or deasserted at beat==len, sets sticky err. Beat count, not rlast, always terminates the burst.
  - A handshake with rid!=latched id also sets err.
  - No handshake for TIMEOUT consecutive cycles -> done with err.
- Done outputs: done_valid is registered, a one-cycle pulse on the cycle after the terminating event. done_id=latched id. A new command is not accepted in the same cycle as done.
- Width: beat is LEN_W bits and is compared exactly to len. len=0 means a single beat with wlast/rd_last on the first beat. Timer saturates at TIMEOUT.

Decomposition:
- Shared package axi_pkg:
  - width localparams: ADDR_W, DATA_W, ID_W, LEN_W
  - state enum: IDLE, AW, W, B, AR, R
  - master id constants: W_ID0=4'b0001, W_ID1=4'b0010, W_ID2=4'b0100, W_ID3=4'b1000
- One natural sub-module, axi_wdog: a clearable saturating timeout counter with enable and a timeout flag. It is used in both B and R.

Test Plan:
- Write id=4'b0001, addr=0x10, len=3, data 0xA0..0xA3 with wready toggling every cycle:
  - awaddr=0x10, awlen=3 on AW.
  - 4 W handshakes, wlast only on 0xA3.
  - done_valid with done_id=1, err=0.
- Read id=4'b0010, addr=0x10, len=3, slave returns 0xA0..0xA3, rd_ready low for 2 cycles mid-burst:
  - rd_data order preserved.
  - rd_last on 4th beat.
  - done err=0.
- Write len=0 with bvalid pulsing in the same cycle as the wlast handshake:
  - b_seen captured, done the next cycle, err=0.
- Write where bvalid never arrives, TIMEOUT=16:
  - done_valid with err=1 exactly 16 cycles after entering B.
- Read len=3 where slave asserts rlast on beat 2:
  - all 4 beats consumed, done_err=1.
- Assert sys_rst during W at beat 2:
  - all outputs 0 immediately.
  - no done pulse.
  - next command starts cleanly from beat 0.
